// File: rtl/tc_pkg.sv
// Shared definitions for the timer_counter peripheral: FSM states, register map,
// CTRL field positions and mode encodings.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PSC_LO  = 4;
    localparam int CTRL_PSC_HI  = 11;
    localparam int PSC_W        = CTRL_PSC_HI - CTRL_PSC_LO + 1;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/tc_prescaler.sv
// Count-enable generator: raises tick once every psc+1 active cycles,
// restarting from zero whenever restart is asserted.
module tc_prescaler
    import tc_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             restart,
    input  logic             active,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;

    assign tick = (psc_cnt == psc);

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            psc_cnt <= '0;
        end else if (active) begin
            psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a locally masked level irq. Define TIMER_PRESCALE_EN for CTRL[11:4] prescaling.
module timer_counter
    import tc_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    state_t           state, next_state;
    logic             ctrl_en, ctrl_im;
    logic [1:0]       ctrl_mode;
    logic [CNT_W-1:0] preset, count;
    logic             irq_flag;
    logic             tick;
    logic [31:0]      ctrl_rd;

    logic ctrl_wr, preset_wr, en_eff;
    logic do_load, do_dec, do_expire, do_en_clr, do_irq_clr;

    assign ctrl_wr   = we && (addr == ADDR_W'(ADDR_CTRL));
    assign preset_wr = we && (addr == ADDR_W'(ADDR_PRESET));
    // The FSM acts on EN as it will be after this cycle's bus write.
    assign en_eff    = ctrl_wr ? wdata[CTRL_EN] : ctrl_en;

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] ctrl_psc;

    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl_psc <= '0;
        end else if (ctrl_wr) begin
            ctrl_psc <= wdata[CTRL_PSC_HI:CTRL_PSC_LO];
        end
    end

    tc_prescaler u_prescaler (
        .clk     (clk),
        .clr     (clr),
        .restart (ctrl_wr || (state == ST_LOAD)),
        .active  (state == ST_CNT),
        .psc     (ctrl_psc),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        do_dec     = 1'b0;
        do_expire  = 1'b0;
        do_en_clr  = 1'b0;
        do_irq_clr = 1'b0;
        case (state)
            ST_IDLE: if (en_eff) next_state = ST_LOAD;
            ST_LOAD: begin
                do_load    = 1'b1;
                next_state = ST_CNT;
            end
            ST_CNT: begin
                if (!en_eff) begin
                    next_state = ST_IDLE;
                end else if (tick) begin
                    if (count <= CNT_W'(1)) begin
                        do_expire  = 1'b1;
                        next_state = ST_INT;
                    end else begin
                        do_dec = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (ctrl_mode == MODE_RELOAD) begin
                    do_irq_clr = 1'b1;
                    next_state = ST_LOAD;
                end else begin
                    do_en_clr  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            irq_flag  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en   <= wdata[CTRL_EN];
                ctrl_mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl_im   <= wdata[CTRL_IM];
            end else if (do_en_clr) begin
                ctrl_en <= 1'b0;
            end

            if (preset_wr) begin
                preset <= wdata[CNT_W-1:0];
            end

            if (do_load) begin
                count <= preset;
            end else if (do_expire) begin
                count <= '0;
            end else if (do_dec) begin
                count <= count - CNT_W'(1);
            end

            // Expiry outranks a coincident register write so an interrupt is never lost.
            if (do_expire) begin
                irq_flag <= 1'b1;
            end else if (ctrl_wr || preset_wr || do_irq_clr) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN] = ctrl_en;
        ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl_mode;
        ctrl_rd[CTRL_IM] = ctrl_im;
`ifdef TIMER_PRESCALE_EN
        ctrl_rd[CTRL_PSC_HI:CTRL_PSC_LO] = ctrl_psc;
`endif
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_W'(ADDR_CTRL)) begin
            rdata = ctrl_rd;
        end else if (addr == ADDR_W'(ADDR_PRESET)) begin
            rdata = 32'(preset);
        end else if (addr == ADDR_W'(ADDR_COUNT)) begin
            rdata = 32'(count);
        end
    end

    assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, auto-reload,
// mid-count disable, masking, expiry/write priority, clr mid-run and optional prescaling.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_counter #(.ADDR_W(2), .CNT_W(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle bus write landing on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        pulse_clr();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_rdata_addr%0d: got %h expected %h", a, v, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);           // edge k
        for (int i = 1; i <= 6; i++) begin
            step();                       // now after edge k+i
            rd(2'd2, v);
            checks++;
            if (v !== 32'(6 - i)) begin
                errors++;
                $display("FAIL oneshot_count_k%0d: got %0d expected %0d", i, v, 6 - i);
            end
            checks++;
            if (irq !== (i == 6)) begin
                errors++;
                $display("FAIL oneshot_irq_k%0d: got %b expected %b", i, irq, (i == 6));
            end
        end
        step();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl_en_cleared: got %h expected %h", v, 32'h8);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_held: got %b expected 1", irq);
        end
        bus_write(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_ctrl_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_reload();
        logic [31:0] v;
        int cnt_tab[5] = '{0, 3, 2, 1, 0};
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);           // edge k: auto-reload, IM, EN
        for (int i = 1; i <= 20; i++) begin
            step();
            rd(2'd2, v);
            checks++;
            if (v !== 32'(cnt_tab[i % 5])) begin
                errors++;
                $display("FAIL reload_count_k%0d: got %0d expected %0d", i, v, cnt_tab[i % 5]);
            end
            checks++;
            if (irq !== ((i % 5) == 4)) begin
                errors++;
                $display("FAIL reload_irq_k%0d: got %b expected %b", i, irq, ((i % 5) == 4));
            end
        end
        bus_write(2'd0, 32'h0);
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reload_stop_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_midcount();
        logic [31:0] v;
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);           // edge k
        for (int i = 1; i <= 5; i++) begin
            step();                       // count reads 11-i
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL midcount_irq_k%0d: got %b expected 0", i, irq);
            end
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL midcount_before_stop: got %0d expected 6", v);
        end
        bus_write(2'd0, 32'h8);           // EN cleared while COUNT=6
        for (int i = 0; i < 4; i++) step();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL midcount_hold: got %0d expected 6", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midcount_irq_after_stop: got %b expected 0", irq);
        end
        bus_write(2'd0, 32'h9);           // re-enable: LOAD next
        step();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("FAIL midcount_reload: got %0d expected 10", v);
        end
        bus_write(2'd0, 32'h0);
    endtask

    task automatic test_mask();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);           // EN, one-shot, IM=0; expiry after k+3
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq_k%0d: got %b expected 0", i, irq);
            end
        end
        bus_write(2'd0, 32'h8);           // IM=1, but the write clears the pending flag
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask_clears: got %b expected 0", irq);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);           // edge k; expiry on edge k+3
        step();
        step();
        bus_write(2'd1, 32'd7);           // lands on edge k+3
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL setwins_irq: got %b expected 1", irq);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL setwins_preset: got %0d expected 7", v);
        end
        step();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8 || irq !== 1'b1) begin
            errors++;
            $display("FAIL setwins_after_int: got ctrl=%h irq=%b expected ctrl=%h irq=1", v, irq, 32'h8);
        end
        bus_write(2'd1, 32'd2);           // plain PRESET write clears the flag
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL preset_write_clears: got %b expected 0", irq);
        end
    endtask

    task automatic test_clr_mid();
        logic [31:0] v;
        bus_write(2'd1, 32'd8);
        bus_write(2'd0, 32'h9);
        for (int i = 0; i < 5; i++) step();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL clr_mid_count_before: got %0d expected 4", v);
        end
        pulse_clr();
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL clr_mid_addr%0d: got %h expected 0", a, v);
            end
        end
        for (int i = 0; i < 4; i++) step();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid_idle: got count=%0d irq=%b expected 0 0", v, irq);
        end

        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);           // expiry after k+2
        step();
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_irq_high_before: got %b expected 1", irq);
        end
        pulse_clr();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_irq_after: got %b expected 0", irq);
        end
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL clr_irq_addr%0d: got %h expected 0", a, v);
            end
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v;
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h29);          // PSC=2, IM, EN; LOAD after edge k
        rd(2'd0, v);
        checks++;
        if (v !== 32'h29) begin
            errors++;
            $display("FAIL psc_ctrl_readback: got %h expected %h", v, 32'h29);
        end
        // Two ticks of three CNT cycles each after the LOAD edge: irq after edge k+7.
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (irq !== (i == 7)) begin
                errors++;
                $display("FAIL psc_irq_k%0d: got %b expected %b", i, irq, (i == 7));
            end
        end
        pulse_clr();
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_midcount();
        test_mask();
        test_set_wins();
        test_clr_mid();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
